// File: rtl/ddr_delay_line.sv
// Programmable per-channel delay line with enable-gated shifting and a
// fill phase that holds valid_o low until every tap carries post-update data.
module ddr_delay_line #(
  parameter int NumChannels = 2,
  parameter int DelayWidth  = 4,
  parameter int DataWidth   = 1,
  parameter int ChanOffset  = 1
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             enable_i,
  input  logic [NumChannels*DataWidth-1:0] data_i,
  input  logic [DelayWidth-1:0]            delay_i,
  input  logic                             delay_valid_i,
  output logic                             delay_ready_o,
  output logic [NumChannels*DataWidth-1:0] data_o,
  output logic                             valid_o
);

  // state | meaning
  // IDLE  | no delay accepted since reset
  // FILL  | new delay latched, waiting for the deepest tap to refill
  // RUN   | data_o reflects the latched delay

  localparam int MaxDelay = 2**DelayWidth - 1;
  localparam int CntWidth = DelayWidth + 1;
  localparam logic [DelayWidth-1:0] MaxCode = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic                  enable_q;
  logic [DelayWidth-1:0] cfg_q, cfg_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [CntWidth-1:0]   fill_target;
  logic                  advance;
  logic                  accept;

  logic [DataWidth-1:0] sr_q [NumChannels][MaxDelay+1];
  logic [DataWidth-1:0] sr_d [NumChannels][MaxDelay+1];

  // Effective tap for a channel: base code plus channel skew, clamped to the last tap.
  function automatic logic [DelayWidth-1:0] eff_delay(input logic [DelayWidth-1:0] code,
                                                      input int chan);
    int sum;
    sum = int'(code) + chan * ChanOffset;
    if (sum > MaxDelay) begin
      return MaxCode;
    end
    return DelayWidth'(sum);
  endfunction

  assign advance     = enable_q;
  assign accept      = delay_valid_i & delay_ready_o;
  // The last channel has the largest (or equal) effective delay.
  assign fill_target = CntWidth'(eff_delay(cfg_q, NumChannels - 1)) + CntWidth'(1);

  // State register and datapath registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      enable_q <= 1'b0;
      cfg_q    <= '0;
      cnt_q    <= '0;
      for (int c = 0; c < NumChannels; c++) begin
        for (int k = 0; k <= MaxDelay; k++) begin
          sr_q[c][k] <= '0;
        end
      end
    end else begin
      state_q  <= state_d;
      enable_q <= enable_i;
      cfg_q    <= cfg_d;
      cnt_q    <= cnt_d;
      sr_q     <= sr_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, RUN: begin
        if (accept) begin
          state_d = FILL;
        end
      end
      FILL: begin
        if (advance && (cnt_q + CntWidth'(1) == fill_target)) begin
          state_d = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    delay_ready_o = (state_q != FILL);
    valid_o       = (state_q == RUN) && enable_q;
  end

  // Configuration latch and fill counter; the accepting cycle never counts.
  always_comb begin
    cfg_d = cfg_q;
    cnt_d = cnt_q;
    if (accept) begin
      cfg_d = delay_i;
      cnt_d = '0;
    end else if ((state_q == FILL) && advance) begin
      cnt_d = cnt_q + CntWidth'(1);
    end
  end

  // Shift registers move only on advance cycles; delay updates never flush them.
  always_comb begin
    sr_d = sr_q;
    if (advance) begin
      for (int c = 0; c < NumChannels; c++) begin
        sr_d[c][0] = data_i[c*DataWidth +: DataWidth];
        for (int k = 1; k <= MaxDelay; k++) begin
          sr_d[c][k] = sr_q[c][k-1];
        end
      end
    end
  end

  always_comb begin
    data_o = '0;
    for (int c = 0; c < NumChannels; c++) begin
      data_o[c*DataWidth +: DataWidth] = sr_q[c][eff_delay(cfg_q, c)];
    end
  end

endmodule
